// File: rtl/learn_costs_param_pkg.sv
// Shared FSM encoding and neighbour-table entry layout for learn_costs_param.
package learn_costs_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_COUNT,
        S_SCAN,
        S_DECIDE,
        S_UPDATE,
        S_APPEND,
        S_EVICT,
        S_DONE
    } state_t;

    // Word offsets inside one table entry
    localparam logic [1:0] OFF_ID   = 2'd0;
    localparam logic [1:0] OFF_BAT  = 2'd1;
    localparam logic [1:0] OFF_COST = 2'd2;
    localparam logic [1:0] OFF_CLU  = 2'd3;
    localparam int         ENTRY_WORDS = 4;

endpackage

// File: rtl/cost_update.sv
// Moves a stored cost toward a new sample by a power-of-two fraction of their gap.
module cost_update #(
    parameter int WORD_WIDTH  = 16,
    parameter int ALPHA_SHIFT = 1
) (
    input  logic [WORD_WIDTH-1:0] old_cost,
    input  logic [WORD_WIDTH-1:0] sample,
    output logic [WORD_WIDTH-1:0] new_cost
);

    // Working on the magnitude of the gap keeps the result between old_cost and sample.
    always_comb begin
        if (sample >= old_cost) begin
            new_cost = old_cost + ((sample - old_cost) >> ALPHA_SHIFT);
        end else begin
            new_cost = old_cost - ((old_cost - sample) >> ALPHA_SHIFT);
        end
    end

endmodule

// File: rtl/learn_costs_param.sv
// Neighbour-table learner: scans a memory-resident table, then updates, appends or evicts one entry.
module learn_costs_param
    import learn_costs_param_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 8,
    parameter int BASE_ADDR     = 0,
    parameter int ALPHA_SHIFT   = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] initial_epsilon,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  evicted,
    output logic [WORD_WIDTH-1:0] neighbor_count,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_cost,
    output logic [WORD_WIDTH-1:0] epsilon
);

    localparam int CW = $clog2(MAX_NEIGHBORS + 1);
    localparam int IW = (MAX_NEIGHBORS > 1) ? $clog2(MAX_NEIGHBORS) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NEIGHBORS);

    state_t                state, state_next;
    logic                  phase;  // 0: address on the bus, 1: data_in captured
    logic [1:0]            field;
    logic [IW-1:0]         idx, target, bat_idx, match_idx;
    logic [CW-1:0]         count, n_final, cnt_in;
    logic [2:0]            wstep;
    logic                  match_found, cur_match, is_evict, last_entry, last_write;
    logic [WORD_WIDTH-1:0] f_id, f_bat, f_val, f_clu, f_eps;
    logic [WORD_WIDTH-1:0] min_bat, old_cost, new_cost, wr_word;
    logic [WORD_WIDTH-1:0] best_id_c, best_cost_c;
    logic [1:0]            wr_off;
    logic [WORD_WIDTH-1:0] id_tab   [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0] cost_tab [MAX_NEIGHBORS];

    cost_update #(.WORD_WIDTH(WORD_WIDTH), .ALPHA_SHIFT(ALPHA_SHIFT)) u_cost (
        .old_cost(old_cost),
        .sample  (f_val),
        .new_cost(new_cost)
    );

    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [IW-1:0] e, input logic [1:0] off);
        return ADDR_WIDTH'(BASE_ADDR + 1) + ADDR_WIDTH'(e) * ADDR_WIDTH'(ENTRY_WORDS) + ADDR_WIDTH'(off);
    endfunction

    assign cnt_in     = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? MAX_CNT : CW'(data_in);
    assign last_entry = (CW'(idx) + CW'(1) == count);

    always_ff @(posedge clock) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (en) state_next = S_RD_COUNT;
            S_RD_COUNT: if (phase) state_next = (cnt_in == '0) ? S_DECIDE : S_SCAN;
            S_SCAN:     if (phase && field == 2'd2 && last_entry) state_next = S_DECIDE;
            S_DECIDE: begin
                if (match_found)           state_next = S_UPDATE;
                else if (count == MAX_CNT) state_next = S_EVICT;
                else                       state_next = S_APPEND;
            end
            S_UPDATE, S_APPEND, S_EVICT: if (last_write) state_next = S_DONE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            S_UPDATE: last_write = (wstep == 3'd2);
            S_APPEND: last_write = (wstep == 3'd4);
            S_EVICT:  last_write = (wstep == 3'd3);
            default:  last_write = 1'b0;
        endcase
    end

    // An update skips the id word, so its write steps start at the battery offset.
    always_comb begin
        wr_off = (state == S_UPDATE) ? wstep[1:0] + 2'd1 : wstep[1:0];
        case (wr_off)
            OFF_ID:   wr_word = f_id;
            OFF_BAT:  wr_word = f_bat;
            OFF_COST: wr_word = (state == S_UPDATE) ? new_cost : f_val;
            default:  wr_word = f_clu;
        endcase
    end

    always_comb begin
        address  = '0;
        wr_en    = 1'b0;
        data_out = '0;
        if (!rst) begin
            case (state)
                S_RD_COUNT: address = ADDR_WIDTH'(BASE_ADDR);
                S_SCAN:     address = entry_addr(idx, field);
                S_UPDATE, S_APPEND, S_EVICT: begin
                    wr_en = 1'b1;
                    if (state == S_APPEND && wstep == 3'd4) begin
                        address  = ADDR_WIDTH'(BASE_ADDR);
                        data_out = WORD_WIDTH'(n_final);
                    end else begin
                        address  = entry_addr(target, wr_off);
                        data_out = wr_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done    = !rst && (state == S_DONE);
    assign busy    = !rst && (state != S_IDLE);
    assign evicted = done && is_evict;

    // Shadow tables already hold the final contents, so the minimum includes the written entry.
    always_comb begin
        best_id_c   = '0;
        best_cost_c = '0;
        for (int i = 0; i < MAX_NEIGHBORS; i++) begin
            if (CW'(i) < n_final && (i == 0 || cost_tab[i] < best_cost_c)) begin
                best_id_c   = id_tab[i];
                best_cost_c = cost_tab[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            phase <= 1'b0;  field <= '0;  idx <= '0;  target <= '0;  bat_idx <= '0;
            match_idx <= '0;  count <= '0;  n_final <= '0;  wstep <= '0;
            match_found <= 1'b0;  cur_match <= 1'b0;  is_evict <= 1'b0;
            f_id <= '0;  f_bat <= '0;  f_val <= '0;  f_clu <= '0;  f_eps <= '0;
            min_bat <= '0;  old_cost <= '0;
            neighbor_count <= '0;  best_id <= '0;  best_cost <= '0;  epsilon <= '0;
        end else begin
            case (state)
                S_IDLE: if (en) begin
                    f_id <= fsourceID;  f_bat <= fbatteryStat;  f_val <= fValue;
                    f_clu <= fclusterID;  f_eps <= initial_epsilon;
                    phase <= 1'b0;  field <= '0;  idx <= '0;  wstep <= '0;
                    match_found <= 1'b0;  cur_match <= 1'b0;
                end
                S_RD_COUNT: begin
                    phase <= ~phase;
                    if (phase) count <= cnt_in;
                end
                S_SCAN: begin
                    phase <= ~phase;
                    if (phase) begin
                        case (field)
                            2'd0: begin
                                id_tab[idx] <= data_in;
                                cur_match   <= (data_in == f_id) && !match_found;
                                if (data_in == f_id && !match_found) begin
                                    match_found <= 1'b1;
                                    match_idx   <= idx;
                                end
                            end
                            2'd1: if (idx == '0 || data_in < min_bat) begin
                                min_bat <= data_in;
                                bat_idx <= idx;
                            end
                            default: begin
                                cost_tab[idx] <= data_in;
                                if (cur_match) old_cost <= data_in;
                            end
                        endcase
                        if (field == 2'd2) begin
                            field <= '0;
                            idx   <= idx + IW'(1);
                        end else begin
                            field <= field + 2'd1;
                        end
                    end
                end
                S_DECIDE: begin
                    wstep    <= '0;
                    is_evict <= 1'b0;
                    if (match_found) begin
                        target              <= match_idx;
                        n_final             <= count;
                        cost_tab[match_idx] <= new_cost;
                        epsilon             <= (epsilon == '0) ? '0 : epsilon - WORD_WIDTH'(1);
                    end else if (count == MAX_CNT) begin
                        target            <= bat_idx;
                        n_final           <= count;
                        is_evict          <= 1'b1;
                        id_tab[bat_idx]   <= f_id;
                        cost_tab[bat_idx] <= f_val;
                        epsilon           <= f_eps;
                    end else begin
                        target                <= IW'(count);
                        n_final               <= count + CW'(1);
                        id_tab[IW'(count)]    <= f_id;
                        cost_tab[IW'(count)]  <= f_val;
                        epsilon               <= f_eps;
                    end
                end
                S_UPDATE, S_APPEND, S_EVICT: begin
                    wstep <= wstep + 3'd1;
                    if (last_write) begin
                        neighbor_count <= WORD_WIDTH'(n_final);
                        best_id        <= best_id_c;
                        best_cost      <= best_cost_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_learn_costs_param.sv
// Directed bench for learn_costs_param with a synchronous-read memory model and an expected-result queue.
module tb_learn_costs_param;

    logic        clock;
    logic        rst, en;
    logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
    logic [15:0] address, data_in, data_out;
    logic        wr_en, done, busy, evicted;
    logic [15:0] neighbor_count, best_id, best_cost, epsilon;

    logic [15:0] mem [65536];
    logic        load_en;
    logic [15:0] load_addr, load_data;
    logic [15:0] exp_q [$];

    int checks = 0, passes = 0, fails = 0;
    int done_cnt = 0, wr_seen = 0;

    learn_costs_param dut (
        .clock(clock), .rst(rst), .en(en),
        .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
        .fclusterID(fclusterID), .initial_epsilon(initial_epsilon),
        .address(address), .wr_en(wr_en), .data_in(data_in), .data_out(data_out),
        .done(done), .busy(busy), .evicted(evicted), .neighbor_count(neighbor_count),
        .best_id(best_id), .best_cost(best_cost), .epsilon(epsilon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (wr_en) mem[address] <= data_out;
        else if (load_en) mem[load_addr] <= load_data;
        data_in <= mem[address];
    end

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (wr_en) wr_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        @(negedge clock);
        load_en = 1'b1;  load_addr = 16'(a);  load_data = 16'(d);
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic run_op(input int id, input int bat, input int val, input int clu, input int eps,
                          input int e_lat, input int e_wr, input int e_bid, input int e_bcost,
                          input int e_cnt, input int e_eps, input int e_ev,
                          input int repulse_at, input string tag);
        int cyc, writes, d0;
        logic got;
        exp_q.push_back(16'(e_lat));  exp_q.push_back(16'(e_wr));
        exp_q.push_back(16'(e_bid));  exp_q.push_back(16'(e_bcost));
        exp_q.push_back(16'(e_cnt));  exp_q.push_back(16'(e_eps));
        exp_q.push_back(16'(e_ev));
        @(negedge clock);
        fsourceID = 16'(id);  fbatteryStat = 16'(bat);  fValue = 16'(val);
        fclusterID = 16'(clu);  initial_epsilon = 16'(eps);  en = 1'b1;
        @(posedge clock);
        d0 = done_cnt;
        #1 en = 1'b0;
        cyc = 0;  writes = 0;  got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (wr_en) writes++;
            if (done) begin
                got = 1'b1;
                check({tag, " latency"}, cyc, exp_q.pop_front());
                check({tag, " writes"}, writes, exp_q.pop_front());
                check({tag, " best_id"}, best_id, exp_q.pop_front());
                check({tag, " best_cost"}, best_cost, exp_q.pop_front());
                check({tag, " count"}, neighbor_count, exp_q.pop_front());
                check({tag, " epsilon"}, epsilon, exp_q.pop_front());
                check({tag, " evicted"}, evicted, exp_q.pop_front());
                check({tag, " busy_at_done"}, busy, 1);
            end
            en = (cyc == repulse_at);
            if (cyc == repulse_at) fsourceID = 16'h0555;
        end
        en = 1'b0;
        if (!got) begin
            check({tag, " done_seen"}, 0, 1);
            exp_q.delete();
        end else begin
            @(negedge clock);
            check({tag, " done_pulse"}, done, 0);
            check({tag, " idle_after"}, busy, 0);
            repeat (30) @(posedge clock);
            check({tag, " done_count"}, done_cnt - d0, 1);
        end
    endtask

    initial begin
        int bats[8]  = '{9, 3, 7, 3, 8, 6, 5, 4};
        int costs[8] = '{50, 40, 30, 60, 25, 70, 45, 35};
        int wr0, d0;
        rst = 1'b1;  en = 1'b0;  load_en = 1'b0;  load_addr = '0;  load_data = '0;
        fsourceID = '0;  fbatteryStat = '0;  fValue = '0;  fclusterID = '0;  initial_epsilon = '0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        check("reset wr_en", wr_en, 0);        check("reset done", done, 0);
        check("reset busy", busy, 0);          check("reset evicted", evicted, 0);
        check("reset address", address, 0);    check("reset data_out", data_out, 0);
        check("reset count", neighbor_count, 0);
        check("reset best_id", best_id, 0);    check("reset best_cost", best_cost, 0);
        check("reset epsilon", epsilon, 0);

        // Empty table: append at index 0
        for (int a = 0; a < 40; a++) poke(a, 0);
        run_op(1, 5, 10, 11, 1,  8, 5,  1, 10, 1, 1, 0, -1, "append_empty");
        check("append_empty mem0", mem[0], 1);  check("append_empty mem1", mem[1], 1);
        check("append_empty mem2", mem[2], 5);  check("append_empty mem3", mem[3], 10);
        check("append_empty mem4", mem[4], 11);

        // Match: cost 20 pulled toward 10 by half the gap
        poke(0, 1);  poke(1, 31);  poke(2, 4);  poke(3, 20);  poke(4, 7);
        run_op(31, 6, 10, 12, 50,  12, 3,  31, 15, 1, 0, 0, -1, "update_down");
        check("update_down mem1", mem[1], 31);  check("update_down mem2", mem[2], 6);
        check("update_down mem3", mem[3], 15);  check("update_down mem4", mem[4], 12);
        check("update_down mem0", mem[0], 1);

        // Match with a rising sample; epsilon already 0 stays 0
        run_op(31, 7, 40, 13, 99,  12, 3,  31, 27, 1, 0, 0, -1, "update_up_sat");
        check("update_up_sat mem3", mem[3], 27);

        // Append with a cost tie: lower index keeps best
        run_op(5, 8, 27, 4, 9,  14, 5,  31, 27, 2, 9, 0, -1, "append_tie");
        check("append_tie mem0", mem[0], 2);  check("append_tie mem5", mem[5], 5);
        check("append_tie mem7", mem[7], 27); check("append_tie mem8", mem[8], 4);

        // Full table: lowest-battery entry (index 1) replaced
        poke(0, 8);
        for (int i = 0; i < 8; i++) begin
            poke(1 + 4 * i, 10 + i);  poke(2 + 4 * i, bats[i]);
            poke(3 + 4 * i, costs[i]); poke(4 + 4 * i, 0);
        end
        poke(33, 1234);
        run_op(99, 2, 20, 3, 7,  55, 4,  99, 20, 8, 7, 1, -1, "evict_full");
        check("evict_full mem0", mem[0], 8);   check("evict_full mem1", mem[1], 10);
        check("evict_full mem5", mem[5], 99);  check("evict_full mem6", mem[6], 2);
        check("evict_full mem7", mem[7], 20);  check("evict_full mem8", mem[8], 3);

        // Count word above capacity is clamped; the evicted entry was the old minimum cost
        poke(0, 12);
        run_op(77, 10, 100, 1, 4,  55, 4,  14, 25, 8, 4, 1, -1, "clamp_count");
        check("clamp_count mem0", mem[0], 12);   check("clamp_count mem5", mem[5], 77);
        check("clamp_count mem7", mem[7], 100);  check("clamp_count mem33", mem[33], 1234);

        // en re-pulsed mid-operation must be ignored
        poke(0, 1);  poke(1, 40);  poke(2, 5);  poke(3, 8);  poke(4, 2);
        run_op(40, 9, 3, 2, 60,  12, 3,  40, 6, 1, 3, 0, 4, "en_while_busy");
        check("en_while_busy mem0", mem[0], 1);  check("en_while_busy mem3", mem[3], 6);
        check("en_while_busy mem5", mem[5], 77);

        // Reset during SCAN
        poke(0, 2);
        poke(1, 50); poke(2, 5); poke(3, 30); poke(4, 1);
        poke(5, 51); poke(6, 6); poke(7, 31); poke(8, 1);
        @(negedge clock);
        fsourceID = 16'd70;  fbatteryStat = 16'd1;  fValue = 16'd1;
        fclusterID = 16'd1;  initial_epsilon = 16'd1;  en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
        wr0 = wr_seen;  d0 = done_cnt;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_scan busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_scan busy", busy, 0);          check("rst_scan done", done, 0);
        check("rst_scan wr_en", wr_en, 0);        check("rst_scan address", address, 0);
        check("rst_scan data_out", data_out, 0);  check("rst_scan evicted", evicted, 0);
        check("rst_scan count", neighbor_count, 0);
        check("rst_scan best_id", best_id, 0);    check("rst_scan best_cost", best_cost, 0);
        check("rst_scan epsilon", epsilon, 0);
        rst = 1'b0;
        repeat (20) @(posedge clock);
        check("rst_scan no_writes", wr_seen - wr0, 0);
        check("rst_scan no_done", done_cnt - d0, 0);
        check("rst_scan table_kept", mem[0], 2);

        // Normal operation resumes after the abort
        run_op(60, 1, 5, 2, 6,  20, 5,  60, 5, 3, 6, 0, -1, "after_reset");
        check("after_reset mem0", mem[0], 3);   check("after_reset mem9", mem[9], 60);
        check("after_reset mem11", mem[11], 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/learn_costs_param.md
LEARN_COSTS_PARAM -- requirements
Module: learn_costs_param

Interface
REQ-001 The block SHALL have these parameters: WORD_WIDTH, default 16, data word width; ADDR_WIDTH, default 16, memory address width; MAX_NEIGHBORS, default 8, table capacity; BASE_ADDR, default 0, table base address; ALPHA_SHIFT, default 1, learning-rate shift.
REQ-002 The block SHALL have one clock, `clock`; reset SHALL be synchronous and active-high, named `rst`.
REQ-003 Ports SHALL be:
- clock  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start pulse.
- fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon  in  WORD_WIDTH  received-packet fields.
- address  out  ADDR_WIDTH  memory address.
- wr_en  out  1  memory write strobe.
- data_in  in  WORD_WIDTH  memory read data.
- data_out  out  WORD_WIDTH  memory write data.
- done  out  1  completion pulse.
- busy  out  1  operation in progress.
- evicted  out  1  pulse with done when an entry was replaced.
- neighbor_count  out  WORD_WIDTH  table occupancy.
- best_id, best_cost  out  WORD_WIDTH  minimum-cost neighbour.
- epsilon  out  WORD_WIDTH  exploration value.

Function
REQ-004 Memory layout SHALL be: word BASE_ADDR = count; entry i occupies BASE_ADDR+1+4i .. +3, holding sourceID, battery, cost and clusterID in that order.
REQ-005 Memory reads SHALL be synchronous: data_in is valid one cycle after address is driven; each read SHALL take 2 cycles (issue, capture), with no pipelining.
REQ-006 en SHALL be sampled only in IDLE, where it latches all packet inputs; en while busy SHALL be ignored.
REQ-007 The FSM SHALL use these states: IDLE -> RD_COUNT -> SCAN (per entry, read id, battery, cost) -> DECIDE -> UPDATE | APPEND | EVICT -> DONE -> IDLE.
REQ-008 A count read greater than MAX_NEIGHBORS SHALL be clamped to MAX_NEIGHBORS.
REQ-009 SCAN SHALL visit all count entries, recording the match index (first match wins), the minimum-battery index (lowest index on ties) and the minimum-cost entry.
REQ-010 UPDATE (match found) SHALL compute new_cost = old + ((fValue-old)>>ALPHA_SHIFT) if fValue>=old, else old - ((old-fValue)>>ALPHA_SHIFT), unsigned with no overflow, then write battery, new_cost and clusterID (3 writes).
REQ-011 APPEND (no match, count<MAX_NEIGHBORS) SHALL write id, battery, cost=fValue and clusterID at index count, then count+1 (5 writes).
REQ-012 EVICT (no match, count==MAX_NEIGHBORS) SHALL overwrite the minimum-battery entry with the 4 new words, leave count unchanged, and assert evicted with done.
REQ-013 Latency from the en cycle to done SHALL be exactly 3 + 6*count + W cycles, where W = 3 for UPDATE, 5 for APPEND, 4 for EVICT.
REQ-014 done SHALL be a 1-cycle pulse in DONE, and busy SHALL be high in every state except IDLE.
REQ-015 In the done cycle, best_id/best_cost SHALL reflect the minimum cost over the final table, including the written or replaced entry, with lowest index winning ties; neighbor_count SHALL hold the final count.
REQ-016 epsilon SHALL load initial_epsilon on APPEND or EVICT, and SHALL decrement by 1 on UPDATE, saturating at 0.
REQ-017 wr_en SHALL be high only during write cycles, one word per cycle.

Reset
REQ-018 On rst, the FSM SHALL go to IDLE, and wr_en, done, busy, evicted, address, data_out, neighbor_count, best_id, best_cost and epsilon SHALL be 0.
REQ-019 rst mid-operation SHALL abort in the same cycle, with no further writes; partial table writes are not rolled back.

Structure
REQ-020 A shared package SHALL hold the state enum, entry field offsets (ID=0, BAT=1, COST=2, CLU=3) and ENTRY_WORDS=4.
REQ-021 The cost update SHALL be a sub-module, cost_update, that is combinational and parametrised by WORD_WIDTH and ALPHA_SHIFT.

Verification
REQ-022 Empty table (count=0), en with id=1, bat=5, val=10, clu=11, eps=1 -> APPEND, memory words 1..4 = 1,5,10,11, count=1, done at cycle 8, best=(1,10), epsilon=1.
REQ-023 Entry id=31 with cost 20 and count=1, en with id=31, val=10, ALPHA_SHIFT=1 -> cost becomes 15, done at cycle 12, epsilon decremented, count unchanged.
REQ-024 Full table (8 entries, batteries 9,3,7,3,...), new id=99 -> entry 1 overwritten, evicted=1, count=8, done at cycle 55.
REQ-025 en pulsed again while busy -> ignored, with exactly one done.
REQ-026 rst asserted during SCAN -> IDLE next cycle, all outputs 0, wr_en never high.
REQ-027 Count word=12 in memory with MAX_NEIGHBORS=8 -> only 8 entries scanned, treated as full.
